// File: rtl/box_pkg.sv
// rtl/box_pkg.sv - shared types and constants for the box_mover controller
package box_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_DRAW  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ERASE = 3'd3,
        ST_MOVE  = 3'd4
    } mover_state_t;

    localparam int DEFAULT_SCREEN_W = 160;
    localparam int DEFAULT_SCREEN_H = 120;

    localparam logic [2:0] ERASE_COLOUR = 3'b000;

endpackage

// File: rtl/box_mover_if.sv
// rtl/box_mover_if.sv - rasterizer request bus between box_mover and the box rasterizer
interface box_mover_if #(
    parameter int X_W    = 8,
    parameter int Y_W    = 7,
    parameter int SIZE_W = 5
);
    logic [X_W-1:0]    box_x;
    logic [Y_W-1:0]    box_y;
    logic [SIZE_W-1:0] box_size;
    logic [2:0]        box_colour;
    logic              box_valid;
    logic              box_ready;

    modport master (
        output box_x, box_y, box_size, box_colour, box_valid,
        input  box_ready
    );

    modport slave (
        input  box_x, box_y, box_size, box_colour, box_valid,
        output box_ready
    );
endinterface

// File: rtl/axis_bounce.sv
// rtl/axis_bounce.sv - next position/direction for one axis, reflecting off both screen edges
module axis_bounce #(
    parameter int W      = 8,
    parameter int SIZE_W = 5,
    parameter int LIMIT  = 160
) (
    input  logic [W-1:0]      i_pos,
    input  logic              i_dir,
    input  logic [SIZE_W-1:0] i_size,
    output logic [W-1:0]      o_pos,
    output logic              o_dir,
    output logic              o_bounce
);
    localparam logic [W:0] LIM = (W+1)'(LIMIT);

    logic [W:0] w_size_ext;
    logic [W:0] w_sum;
    logic [W:0] w_edge;

    assign w_size_ext = {{(W+1-SIZE_W){1'b0}}, i_size};
    assign w_sum      = {1'b0, i_pos} + w_size_ext;
    // Touching the edge steps back by one; overshooting (size grew) lands exactly on it.
    assign w_edge     = LIM - w_size_ext - {{W{1'b0}}, (w_sum == LIM)};

    always_comb begin
        o_pos    = i_pos;
        o_dir    = i_dir;
        o_bounce = 1'b0;
        if (i_dir) begin
            if (w_sum >= LIM) begin
                o_pos    = w_edge[W-1:0];
                o_dir    = 1'b0;
                o_bounce = 1'b1;
            end else begin
                o_pos = i_pos + W'(1);
            end
        end else begin
            if (i_pos == '0) begin
                o_pos    = W'(1);
                o_dir    = 1'b1;
                o_bounce = 1'b1;
            end else begin
                o_pos = i_pos - W'(1);
            end
        end
    end
endmodule

// File: rtl/box_mover.sv
// rtl/box_mover.sv - per-frame erase/move/draw sequencer for one bouncing square sprite
module box_mover
    import box_pkg::*;
#(
    parameter int SCREEN_W        = DEFAULT_SCREEN_W,
    parameter int SCREEN_H        = DEFAULT_SCREEN_H,
    parameter int X_W             = 8,
    parameter int Y_W             = 7,
    parameter int SIZE_W          = 5,
    parameter int FRAMES_PER_STEP = 4,
    parameter int START_X         = 0,
    parameter int START_Y         = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              frame_tick,
    input  logic [SIZE_W-1:0] size,
    input  logic [2:0]        colour,
    box_mover_if.master       bus,
    output logic              bounce_x,
    output logic              bounce_y
);
    localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);
    localparam logic [X_W:0] LIM_X = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] LIM_Y = (Y_W+1)'(SCREEN_H);

    mover_state_t      r_state;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic              r_dir_x;
    logic              r_dir_y;
    logic [SIZE_W-1:0] r_size;
    logic [2:0]        r_colour;
    logic              r_valid;
    logic [CNT_W-1:0]  r_cnt;

    logic [X_W:0]   w_init_xsum;
    logic [Y_W:0]   w_init_ysum;
    logic [X_W:0]   w_init_xfit;
    logic [Y_W:0]   w_init_yfit;
    logic [X_W-1:0] w_init_x;
    logic [Y_W-1:0] w_init_y;
    logic [X_W-1:0] w_next_x;
    logic [Y_W-1:0] w_next_y;
    logic           w_next_dir_x;
    logic           w_next_dir_y;
    logic           w_bounce_x;
    logic           w_bounce_y;

    // Initial clamp pulls the box back inside when the start position plus size overhangs.
    assign w_init_xsum = {1'b0, r_x} + {{(X_W+1-SIZE_W){1'b0}}, size};
    assign w_init_ysum = {1'b0, r_y} + {{(Y_W+1-SIZE_W){1'b0}}, size};
    assign w_init_xfit = LIM_X - {{(X_W+1-SIZE_W){1'b0}}, size};
    assign w_init_yfit = LIM_Y - {{(Y_W+1-SIZE_W){1'b0}}, size};
    assign w_init_x    = (w_init_xsum > LIM_X) ? w_init_xfit[X_W-1:0] : r_x;
    assign w_init_y    = (w_init_ysum > LIM_Y) ? w_init_yfit[Y_W-1:0] : r_y;

    // The step uses the size sampled in MOVE, so a growing box reflects immediately.
    axis_bounce #(.W(X_W), .SIZE_W(SIZE_W), .LIMIT(SCREEN_W)) u_axis_x (
        .i_pos    (r_x),
        .i_dir    (r_dir_x),
        .i_size   (size),
        .o_pos    (w_next_x),
        .o_dir    (w_next_dir_x),
        .o_bounce (w_bounce_x)
    );

    axis_bounce #(.W(Y_W), .SIZE_W(SIZE_W), .LIMIT(SCREEN_H)) u_axis_y (
        .i_pos    (r_y),
        .i_dir    (r_dir_y),
        .i_size   (size),
        .o_pos    (w_next_y),
        .o_dir    (w_next_dir_y),
        .o_bounce (w_bounce_y)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_INIT;
            r_x      <= X_W'(START_X);
            r_y      <= Y_W'(START_Y);
            r_dir_x  <= 1'b1;
            r_dir_y  <= 1'b1;
            r_size   <= '0;
            r_colour <= ERASE_COLOUR;
            r_valid  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_size   <= size;
                    r_x      <= w_init_x;
                    r_y      <= w_init_y;
                    r_colour <= colour;
                    r_valid  <= 1'b1;
                    r_state  <= ST_DRAW;
                end
                ST_DRAW: begin
                    if (r_valid && bus.box_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (enable && frame_tick) begin
                        if (r_cnt == CNT_LAST) begin
                            r_cnt    <= '0;
                            r_colour <= ERASE_COLOUR;
                            r_valid  <= 1'b1;
                            r_state  <= ST_ERASE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_ERASE: begin
                    if (r_valid && bus.box_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    r_size   <= size;
                    r_x      <= w_next_x;
                    r_y      <= w_next_y;
                    r_dir_x  <= w_next_dir_x;
                    r_dir_y  <= w_next_dir_y;
                    r_colour <= colour;
                    r_valid  <= 1'b1;
                    r_state  <= ST_DRAW;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign bus.box_x      = r_x;
    assign bus.box_y      = r_y;
    assign bus.box_size   = r_size;
    assign bus.box_colour = r_colour;
    assign bus.box_valid  = r_valid;

    assign bounce_x = (r_state == ST_MOVE) && w_bounce_x;
    assign bounce_y = (r_state == ST_MOVE) && w_bounce_y;
endmodule
